// File: rtl/nram_pkg.sv
// Shared definitions for the NRAM FIFO controller: FSM state encoding and
// default data/address widths.
package nram_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 2;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_e;

endpackage

// File: rtl/nram_ptr_ctrl.sv
// Write/read pointer and occupancy bookkeeping for the NRAM FIFO controller.
// clr_i returns everything to zero and dominates any same-cycle fire.
module nram_ptr_ctrl #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          enq_fire_i,
  input  logic          deq_fire_i,
  output logic [AW-1:0] wptr_o,
  output logic [AW-1:0] rptr_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointers wrap naturally through their AW-bit width.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (enq_fire_i) wptr_d = wptr_q + PTR_ONE;
    if (deq_fire_i) rptr_d = rptr_q + PTR_ONE;
    if (enq_fire_i && !deq_fire_i)      count_d = count_q + CNT_ONE;
    else if (!enq_fire_i && deq_fire_i) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;

endmodule

// File: rtl/nram_fifo_ctrl.sv
// FIFO controller around an external asynchronous-read NRAM of depth 2**AW.
// Optional synchronous flush input enabled by defining NRAM_FIFO_FLUSH_EN.
module nram_fifo_ctrl
  import nram_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
`ifdef NRAM_FIFO_FLUSH_EN
  input  logic          io_flush,
`endif
  input  logic          io_enq_valid,
  output logic          io_enq_ready,
  input  logic [DW-1:0] io_enq_bits,
  output logic          io_deq_valid,
  input  logic          io_deq_ready,
  output logic [DW-1:0] io_deq_bits,
  output logic [DW-1:0] io_ram_D,
  output logic [AW-1:0] io_ram_WADD,
  output logic          io_ram_WE,
  output logic [AW-1:0] io_ram_RADD,
  input  logic [DW-1:0] io_ram_Q,
  output logic [AW:0]   io_count
);

  localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] CNT_ONE  = 1;

  state_e state_q;
  logic   clr;
  logic   enq_fire;
  logic   deq_fire;

`ifdef NRAM_FIFO_FLUSH_EN
  assign clr          = reset | io_flush;
  assign io_enq_ready = (state_q != FULL) && !io_flush;
`else
  assign clr          = reset;
  assign io_enq_ready = (state_q != FULL);
`endif

  assign io_deq_valid = (state_q != EMPTY);
  assign enq_fire     = io_enq_valid && io_enq_ready;
  assign deq_fire     = io_deq_valid && io_deq_ready;

  // Reset must not corrupt the NRAM, so the strobe is masked in that cycle.
  assign io_ram_WE   = enq_fire && !reset;
  assign io_ram_D    = io_enq_bits;
  assign io_deq_bits = io_ram_Q;

  nram_ptr_ctrl #(.AW(AW)) u_ptr (
    .clk        (clk),
    .clr_i      (clr),
    .enq_fire_i (enq_fire),
    .deq_fire_i (deq_fire),
    .wptr_o     (io_ram_WADD),
    .rptr_o     (io_ram_RADD),
    .count_o    (io_count)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY:  if (enq_fire) state_q <= ACTIVE;
        ACTIVE: begin
          if (enq_fire && !deq_fire && io_count == CNT_LAST)
            state_q <= FULL;
          else if (deq_fire && !enq_fire && io_count == CNT_ONE)
            state_q <= EMPTY;
        end
        FULL:   if (deq_fire) state_q <= ACTIVE;
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_nram_fifo_ctrl.sv
// Scoreboard bench for nram_fifo_ctrl with a behavioural queue model and an
// NRAM array model; flush tests compile in when NRAM_FIFO_FLUSH_EN is defined.
module tb_nram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_flush;
  logic          io_enq_valid;
  logic          io_enq_ready;
  logic [DW-1:0] io_enq_bits;
  logic          io_deq_valid;
  logic          io_deq_ready;
  logic [DW-1:0] io_deq_bits;
  logic [DW-1:0] io_ram_D;
  logic [AW-1:0] io_ram_WADD;
  logic          io_ram_WE;
  logic [AW-1:0] io_ram_RADD;
  logic [DW-1:0] io_ram_Q;
  logic [AW:0]   io_count;

  nram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef NRAM_FIFO_FLUSH_EN
    .io_flush     (io_flush),
`endif
    .io_enq_valid (io_enq_valid),
    .io_enq_ready (io_enq_ready),
    .io_enq_bits  (io_enq_bits),
    .io_deq_valid (io_deq_valid),
    .io_deq_ready (io_deq_ready),
    .io_deq_bits  (io_deq_bits),
    .io_ram_D     (io_ram_D),
    .io_ram_WADD  (io_ram_WADD),
    .io_ram_WE    (io_ram_WE),
    .io_ram_RADD  (io_ram_RADD),
    .io_ram_Q     (io_ram_Q),
    .io_count     (io_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (io_ram_WE) mem[io_ram_WADD] <= io_ram_D;
  assign io_ram_Q = mem[io_ram_RADD];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];
  int mcnt = 0;
  int mw   = 0;
  int mr   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input logic r, input logic fl, input logic ev,
                      input logic [DW-1:0] eb, input logic dr);
    logic efire, dfire;
    reset = r; io_flush = fl; io_enq_valid = ev; io_enq_bits = eb; io_deq_ready = dr;
    #1;
    efire = ev && !fl && (mcnt != DEPTH);
    dfire = dr && (mcnt != 0);
    chk("count",     int'(io_count),     mcnt);
    chk("enq_ready", int'(io_enq_ready), int'(mcnt != DEPTH && !fl));
    chk("deq_valid", int'(io_deq_valid), int'(mcnt != 0));
    chk("ram_we",    int'(io_ram_WE),    int'(efire && !r));
    chk("ram_wadd",  int'(io_ram_WADD),  mw);
    chk("ram_radd",  int'(io_ram_RADD),  mr);
    chk("ram_d",     int'(io_ram_D),     int'(eb));
    if (r || fl) begin
      mcnt = 0; mw = 0; mr = 0;
      exp_q.delete();
    end else begin
      if (efire) begin
        exp_q.push_back(eb);
        mw = (mw + 1) % DEPTH;
      end
      if (dfire) mr = (mr + 1) % DEPTH;
      mcnt = mcnt + int'(efire) - int'(dfire);
    end
    @(negedge clk);
  endtask

  // Monitor: every real dequeue must present the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && !io_flush && io_deq_valid && io_deq_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL deq_unexpected: got %0d expected no output", io_deq_bits);
        end else begin
          chk("deq_bits", int'(io_deq_bits), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    reset = 1'b1; io_flush = 1'b0; io_enq_valid = 1'b0; io_enq_bits = '0; io_deq_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);

    step(0, 0, 1, 8'h11, 0);
    step(0, 0, 1, 8'h22, 0);
    step(0, 0, 1, 8'h33, 0);
    step(0, 0, 1, 8'h44, 0);
    step(0, 0, 1, 8'h55, 0);
    step(0, 0, 0, 8'h00, 0);

    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);

    step(0, 0, 1, 8'hA0, 0);
    step(0, 0, 1, 8'hA1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, DW'(8'hB0 + i), 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 0);

    step(0, 0, 1, 8'hC1, 0);
    step(0, 0, 1, 8'hC2, 0);
    step(0, 0, 1, 8'hC3, 0);
    step(1, 0, 1, 8'hC4, 0);
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'hD1, 0);
    step(0, 0, 0, 8'h00, 1);

`ifdef NRAM_FIFO_FLUSH_EN
    step(0, 0, 1, 8'hE1, 0);
    step(0, 0, 1, 8'hE2, 0);
    step(0, 1, 1, 8'hE3, 1);
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'hE4, 0);
    step(0, 0, 0, 8'h00, 1);
`endif

    for (int i = 0; i < 800; i++) begin
      int phase;
      logic r, fl, ev, dr;
      phase = (i / 100) % 3;
      r  = ($urandom_range(0, 79) == 0);
`ifdef NRAM_FIFO_FLUSH_EN
      fl = ($urandom_range(0, 59) == 0);
`else
      fl = 1'b0;
`endif
      ev = (phase == 0) ? ($urandom_range(0, 3) != 0) : (phase == 1) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1);
      dr = (phase == 0) ? ($urandom_range(0, 3) == 0) : (phase == 1) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1);
      step(r, fl, ev, DW'($urandom), dr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
